axis_frame_arbiter: RTL and testbench

// - Frame-aware round-robin arbiter: merges N AXI-Stream sources (typically per-queue axis_fifo outputs) onto one stream.
// - Grant is locked from the first beat of a frame until its tlast, so frames are never interleaved.
// - Stall watchdog: a source that stalls mid-frame gets its frame terminated with a bad-frame beat.
//   A downstream frame FIFO with DROP_BAD_FRAME then discards that frame.

---
 rtl/axis_arb_pkg.sv | 33 +++
 rtl/axis_skid_buffer.sv | 49 ++++
 rtl/axis_frame_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-aware AXI-Stream arbiter.
// Round-robin pick logic lives here so the top only holds state.
package axis_arb_pkg;

   typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

   localparam int MAX_PORTS = 16;

   function automatic int stall_w(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

   // First requesting index after 'last', wrapping modulo n (n need not be a power of 2).
   function automatic int rr_pick(input logic [MAX_PORTS-1:0] req, input int last, input int n);
      int  pick;
      int  idx;
      logic found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         idx = last + k;
         if (idx >= n) idx = idx - n;
         if (k <= n && !found && idx < MAX_PORTS) begin
            if (req[idx[3:0]]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output register stage: a beat pushed into an empty buffer is visible next cycle.
// Input ready depends only on occupancy, never combinationally on m_rdy.
module axis_skid_buffer #(
   parameter int W = 74
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] s_dat,
   input  logic         s_vld,
   output logic         s_rdy,
   output logic [W-1:0] m_dat,
   output logic         m_vld,
   input  logic         m_rdy
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   assign s_rdy = (count != 2'd2);
   assign m_vld = (count != 2'd0);
   assign m_dat = mem[rd_ptr];
   assign push  = s_vld && s_rdy;
   assign pop   = m_vld && m_rdy;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-locked round-robin merge of S_COUNT AXI-Stream sources, with a mid-frame stall watchdog.
// One bubble per frame for arbitration; output is a 2-entry skid buffer so input ready never sees m_axis_tready.
module axis_frame_arbiter
   import axis_arb_pkg::*;
#(
   parameter int                    S_COUNT        = 4,
   parameter int                    DATA_WIDTH     = 64,
   parameter int                    KEEP_WIDTH     = DATA_WIDTH/8,
   parameter int                    USER_WIDTH     = 1,
   parameter logic [USER_WIDTH-1:0] USER_BAD_VALUE = USER_WIDTH'(1),
   parameter int                    STALL_TIMEOUT  = 256
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
   input  logic [S_COUNT-1:0]               s_axis_tvalid,
   output logic [S_COUNT-1:0]               s_axis_tready,
   input  logic [S_COUNT-1:0]               s_axis_tlast,
   input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [USER_WIDTH-1:0]            m_axis_tuser,
   output logic [$clog2(S_COUNT)-1:0]       status_grant,
   output logic                             status_busy,
   output logic [S_COUNT-1:0]               status_abort
);

   localparam int GRANT_W = $clog2(S_COUNT);
   localparam int STALL_W = stall_w(STALL_TIMEOUT);
   localparam int BEAT_W  = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'((STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1);

   state_t               state;
   logic [GRANT_W-1:0]   grant;
   logic [GRANT_W-1:0]   last_grant;
   logic [STALL_W-1:0]   stall_cnt;
   logic [S_COUNT-1:0]   drop;
   logic [S_COUNT-1:0]   eligible;
   logic [MAX_PORTS-1:0] req_pad;
   int                   pick;
   logic                 sel_vld;
   logic                 sel_last;
   logic                 accept;
   logic                 abort_push;
   logic                 skid_rdy;
   logic [BEAT_W-1:0]    push_dat;
   logic [BEAT_W-1:0]    m_beat;

   assign eligible   = s_axis_tvalid & ~drop;
   assign sel_vld    = s_axis_tvalid[grant];
   assign sel_last   = s_axis_tlast[grant];
   assign accept     = (state == XFER) && sel_vld && skid_rdy;
   assign abort_push = (state == ABORT) && skid_rdy;
   assign status_grant = grant;
   assign status_busy  = (state == XFER);

   always_comb begin
      req_pad = '0;
      req_pad[S_COUNT-1:0] = eligible;
      pick = rr_pick(req_pad, int'(last_grant), S_COUNT);
   end

   // Dropping ports drain regardless of the FSM; only the granted port may feed the buffer.
   always_comb begin
      s_axis_tready = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         s_axis_tready[i] = drop[i] || ((state == XFER) && (grant == GRANT_W'(i)) && skid_rdy);
      end
   end

   always_comb begin
      if (state == ABORT) begin
         push_dat = {{DATA_WIDTH{1'b0}}, KEEP_WIDTH'(1), 1'b1, USER_BAD_VALUE};
      end else begin
         push_dat = {s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH],
                     s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH],
                     sel_last,
                     s_axis_tuser[int'(grant)*USER_WIDTH +: USER_WIDTH]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         last_grant   <= GRANT_W'(S_COUNT - 1);
         stall_cnt    <= '0;
         drop         <= '0;
         status_abort <= '0;
      end else begin
         status_abort <= '0;
         for (int i = 0; i < S_COUNT; i++) begin
            if (drop[i] && s_axis_tvalid[i] && s_axis_tlast[i]) drop[i] <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (|eligible) begin
                  grant     <= GRANT_W'(pick);
                  stall_cnt <= '0;
                  state     <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  stall_cnt <= '0;
                  if (sel_last) begin
                     last_grant <= grant;
                     state      <= IDLE;
                  end
               end else if (!sel_vld && STALL_TIMEOUT != 0) begin
                  // Backpressure cycles (valid held, buffer full) never advance the watchdog.
                  if (stall_cnt == STALL_LIM) state <= ABORT;
                  else                        stall_cnt <= stall_cnt + STALL_W'(1);
               end
            end
            ABORT: begin
               if (skid_rdy) begin
                  drop[grant]         <= 1'b1;
                  status_abort[grant] <= 1'b1;
                  last_grant          <= grant;
                  state               <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axis_skid_buffer #(.W(BEAT_W)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .s_dat (push_dat),
      .s_vld (accept || abort_push),
      .s_rdy (skid_rdy),
      .m_dat (m_beat),
      .m_vld (m_axis_tvalid),
      .m_rdy (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = m_beat;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomized bench for axis_frame_arbiter: per-port frame queues drive the inputs,
// a round-robin frame-level model predicts the merged output stream.
module tb_axis_frame_arbiter;

   localparam int S  = 4;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int UW = 1;
   localparam int TO = 8;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic [7:0]  gap;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [S*DW-1:0]   s_tdata;
   logic [S*KW-1:0]   s_tkeep;
   logic [S-1:0]      s_tvalid;
   logic [S-1:0]      s_tready;
   logic [S-1:0]      s_tlast;
   logic [S*UW-1:0]   s_tuser;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic [UW-1:0]     m_tuser;
   logic [1:0]        status_grant;
   logic              status_busy;
   logic [S-1:0]      status_abort;

   always #5 clk = ~clk;

   axis_frame_arbiter #(
      .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
      .USER_BAD_VALUE(1'b1), .STALL_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .status_grant(status_grant), .status_busy(status_busy), .status_abort(status_abort)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          frame_id = 0;
   beat_t       src_q [S][$];
   int          gap_cnt [S];
   beat_t       exp_q [$];
   int          last_cyc [$];
   logic        sb_en = 1'b1;
   logic        rand_rdy = 1'b0;
   int          hold_lo = 0;
   logic [S-1:0] abort_seen = '0;
   int          abort_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [73:0] prev_m = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [73:0] beat_bits(input beat_t b);
      return {b.data, b.keep, b.last, b.user};
   endfunction

   function automatic logic src_busy();
      logic busy = 1'b0;
      for (int i = 0; i < S; i++) if (src_q[i].size() > 0) busy = 1'b1;
      return busy;
   endfunction

   // One cycle: drive inputs after negedge, observe settled outputs, account for the coming handshakes.
   task automatic step();
      logic [73:0] cur_m;
      beat_t       h;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < S; i++) begin
         if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
            h = src_q[i][0];
            s_tvalid[i] = 1'b1;
            s_tdata[i*DW +: DW] = h.data;
            s_tkeep[i*KW +: KW] = h.keep;
            s_tlast[i] = h.last;
            s_tuser[i*UW +: UW] = h.user;
         end else begin
            s_tvalid[i] = 1'b0;
            s_tdata[i*DW +: DW] = '0;
            s_tkeep[i*KW +: KW] = '0;
            s_tlast[i] = 1'b0;
            s_tuser[i*UW +: UW] = '0;
         end
      end
      if (!rand_rdy) begin
         m_tready = 1'b1;
      end else if (hold_lo > 0) begin
         m_tready = 1'b0;
         hold_lo--;
      end else begin
         m_tready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) hold_lo = 15;
      end
      #1;
      cur_m = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (prev_stall) check("hold_stable", 128'({m_tvalid, cur_m}), 128'({1'b1, prev_m}));
      prev_stall = m_tvalid && !m_tready;
      prev_m = cur_m;
      if (status_abort != '0) begin
         abort_seen = abort_seen | status_abort;
         abort_cnt++;
      end
      if (m_tvalid && m_tready && sb_en) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 128'(exp_q.size()), 128'd1);
         end else begin
            h = exp_q.pop_front();
            check("out_beat", 128'(cur_m), 128'(beat_bits(h)));
            if (cur_m[1]) last_cyc.push_back(cyc);
         end
      end
      for (int i = 0; i < S; i++) begin
         if (s_tvalid[i] && s_tready[i]) begin
            void'(src_q[i].pop_front());
            gap_cnt[i] = (src_q[i].size() > 0) ? int'(src_q[i][0].gap) : 0;
         end else if (src_q[i].size() > 0 && gap_cnt[i] > 0) begin
            gap_cnt[i]--;
         end
      end
   endtask

   task automatic add_frame(input int p, input int len, input bit gaps);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {8'(p), 16'(frame_id), 8'(k), 32'($urandom)};
         b.keep = 8'($urandom_range(1, 255));
         b.last = (k == len - 1);
         b.user = 1'($urandom_range(0, 1));
         b.gap  = (gaps && k > 0 && $urandom_range(0, 9) < 3) ? 8'($urandom_range(1, 3)) : 8'd0;
         src_q[p].push_back(b);
      end
      frame_id++;
   endtask

   // Every loaded port is valid at each frame boundary, so the merged order is plain round-robin over whole frames.
   task automatic build_expected(input int last);
      beat_t cp [S][$];
      beat_t b;
      int    p;
      for (int i = 0; i < S; i++) cp[i] = src_q[i];
      p = 0;
      while (p >= 0) begin
         p = -1;
         for (int k = 1; k <= S; k++) if (p < 0 && cp[(last + k) % S].size() > 0) p = (last + k) % S;
         if (p >= 0) begin
            do begin
               b = cp[p].pop_front();
               exp_q.push_back(b);
            end while (!b.last);
            last = p;
         end
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || src_busy()) && n < budget) begin
         step();
         n++;
      end
      check("within_budget", 128'(n < budget), 128'd1);
      for (int k = 0; k < 4; k++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      prev_stall = 1'b0;
      for (int i = 0; i < S; i++) begin
         src_q[i].delete();
         gap_cnt[i] = 0;
      end
      exp_q.delete();
      last_cyc.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      beat_t b;
      int    guard;
      s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
      for (int i = 0; i < S; i++) gap_cnt[i] = 0;

      // Reset state
      do_reset();
      check("rst_m_tvalid", 128'(m_tvalid), 128'd0);
      check("rst_s_tready", 128'(s_tready), 128'd0);
      check("rst_grant", 128'(status_grant), 128'd0);
      check("rst_busy", 128'(status_busy), 128'd0);
      check("rst_abort", 128'(status_abort), 128'd0);

      // Round-robin fairness with 3-beat frames on all ports
      for (int r = 0; r < 3; r++) for (int p = 0; p < S; p++) add_frame(p, 3, 1'b0);
      build_expected(S - 1);
      run(400);
      check("rr_frames", 128'(last_cyc.size()), 128'd12);
      for (int k = 1; k < last_cyc.size(); k++) check("rr_spacing", 128'(last_cyc[k] - last_cyc[k-1]), 128'd4);

      // Random backpressure and mid-frame gaps across 1000 frames
      do_reset();
      rand_rdy = 1'b1;
      abort_cnt = 0;
      for (int r = 0; r < 250; r++) for (int p = 0; p < S; p++) add_frame(p, $urandom_range(1, 4), 1'b1);
      build_expected(S - 1);
      run(40000);
      check("rand_frames", 128'(last_cyc.size()), 128'd1000);
      check("rand_no_abort", 128'(abort_cnt), 128'd0);
      rand_rdy = 1'b0;

      // Single-beat frames on ports 1 and 3
      do_reset();
      for (int r = 0; r < 4; r++) begin
         add_frame(1, 1, 1'b0);
         add_frame(3, 1, 1'b0);
      end
      build_expected(S - 1);
      run(200);
      check("sb_frames", 128'(last_cyc.size()), 128'd8);
      for (int k = 1; k < last_cyc.size(); k++) check("sb_spacing", 128'(last_cyc[k] - last_cyc[k-1]), 128'd2);
      check("sb_last_grant", 128'(status_grant), 128'd3);

      // Watchdog: port 2 stalls for 8 cycles after two beats, then finishes a doomed frame and sends a fresh one
      do_reset();
      abort_cnt = 0;
      abort_seen = '0;
      add_frame(2, 5, 1'b0);
      b = src_q[2][2];
      b.gap = 8'd8;
      src_q[2][2] = b;
      add_frame(2, 2, 1'b0);
      exp_q.push_back(src_q[2][0]);
      exp_q.push_back(src_q[2][1]);
      b = '0;
      b.keep = 8'd1;
      b.last = 1'b1;
      b.user = 1'b1;
      exp_q.push_back(b);
      exp_q.push_back(src_q[2][5]);
      exp_q.push_back(src_q[2][6]);
      run(300);
      check("wd_abort_port", 128'(abort_seen), 128'(4'b0100));
      check("wd_abort_pulses", 128'(abort_cnt), 128'd1);
      check("wd_frames", 128'(last_cyc.size()), 128'd2);

      // Reset in the middle of a 5-beat frame
      do_reset();
      sb_en = 1'b0;
      add_frame(0, 5, 1'b0);
      add_frame(1, 2, 1'b0);
      guard = 0;
      while (src_q[0].size() > 3 && guard < 50) begin
         step();
         guard++;
      end
      check("mid_reach", 128'(guard < 50), 128'd1);
      step();
      rst_n = 1'b0;
      prev_stall = 1'b0;
      for (int i = 0; i < S; i++) begin
         src_q[i].delete();
         gap_cnt[i] = 0;
      end
      step();
      check("mid_rst_m_tvalid", 128'(m_tvalid), 128'd0);
      check("mid_rst_busy", 128'(status_busy), 128'd0);
      check("mid_rst_s_tready", 128'(s_tready), 128'd0);
      step();
      rst_n = 1'b1;
      sb_en = 1'b1;
      last_cyc.delete();
      add_frame(1, 3, 1'b0);
      add_frame(0, 3, 1'b0);
      build_expected(S - 1);
      run(200);
      check("mid_frames", 128'(last_cyc.size()), 128'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
